// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup, EX training and RAS flush signals of the branch predictor.
interface branch_predictor_if #(parameter int XLEN = 32);
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic            pred_valid;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic [1:0]      pred_state;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic [1:0]      upd_type;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            ras_flush;
  modport master (
    output if_valid, if_pc, upd_valid, upd_pc, upd_type, upd_taken, upd_target, ras_flush,
    input  pred_valid, pred_taken, pred_target, pred_state
  );
  modport slave (
    input  if_valid, if_pc, upd_valid, upd_pc, upd_type, upd_taken, upd_target, ras_flush,
    output pred_valid, pred_taken, pred_target, pred_state
  );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, optional return address stack.
// Define BRANCH_PRED_RAS_EN to build the RAS; otherwise returns predict their stored target.
module branch_predictor #(
  parameter int XLEN     = 32,
  parameter int BTB_SIZE = 64,
  parameter int RAS_SIZE = 8
) (
  input logic clk,
  input logic rst,
  branch_predictor_if.slave bp
);
  typedef enum logic [1:0] {STRONG_NT, WEAK_NT, WEAK_TAKEN, STRONG_TAKEN} branch_pred_state_e;
  typedef enum logic [1:0] {T_BRANCH, T_JUMP, T_CALL, T_RET} cf_type_e;
  localparam int IW = $clog2(BTB_SIZE);
  localparam int TW = XLEN - IW - 2;
  localparam int RW = $clog2(RAS_SIZE);
  logic [BTB_SIZE-1:0] valid;
  logic [TW-1:0]       tag    [BTB_SIZE];
  logic [1:0]          typ    [BTB_SIZE];
  logic [XLEN-1:0]     target [BTB_SIZE];
  logic [1:0]          cnt    [BTB_SIZE];
  logic [IW-1:0]       ri, ui;
  logic                hit, u_hit, u_same, u_alloc;
  logic [1:0]          u_cnt;
  logic [XLEN-1:0]     seq_pc;
  logic [3:0]          unused_lsb;
  assign unused_lsb = {bp.if_pc[1:0], bp.upd_pc[1:0]};
  assign ri      = bp.if_pc[IW+1:2];
  assign ui      = bp.upd_pc[IW+1:2];
  assign hit     = valid[ri] && tag[ri] == bp.if_pc[XLEN-1:IW+2];
  assign u_hit   = valid[ui] && tag[ui] == bp.upd_pc[XLEN-1:IW+2];
  assign u_same  = u_hit && typ[ui] == bp.upd_type;
  // A type change on a hit re-allocates even when not taken, so stale types never linger
  assign u_alloc = !u_same && (bp.upd_taken || u_hit);
  assign u_cnt   = bp.upd_taken ? (cnt[ui] == 2'b11 ? 2'b11 : cnt[ui] + 2'b01)
                                : (cnt[ui] == 2'b00 ? 2'b00 : cnt[ui] - 2'b01);
  assign seq_pc         = bp.if_pc + XLEN'(4);
  assign bp.pred_valid  = hit;
  assign bp.pred_taken  = hit && (typ[ri] != T_BRANCH || cnt[ri][1]);
  assign bp.pred_state  = hit ? cnt[ri] : STRONG_NT;
  always_ff @(posedge clk or posedge rst)
    if (rst) valid <= '0;
    else if (bp.upd_valid && !u_same && u_alloc) valid[ui] <= 1'b1;
  always_ff @(posedge clk)
    if (bp.upd_valid) begin
      if (u_same) begin
        if (bp.upd_type == T_BRANCH) cnt[ui] <= u_cnt;
        if (bp.upd_taken) target[ui] <= bp.upd_target;
      end else if (u_alloc) begin
        tag[ui]    <= bp.upd_pc[XLEN-1:IW+2];
        typ[ui]    <= bp.upd_type;
        target[ui] <= bp.upd_target;
        cnt[ui]    <= bp.upd_type == T_BRANCH ? WEAK_TAKEN : STRONG_TAKEN;
      end
    end
`ifdef BRANCH_PRED_RAS_EN
  logic [XLEN-1:0] ras [RAS_SIZE];
  logic [RW-1:0]   ptr;
  logic [RW:0]     depth;
  logic            push, pop, ras_ret;
  assign ras_ret = hit && typ[ri] == T_RET && depth != '0;
  assign push    = bp.if_valid && hit && typ[ri] == T_CALL;
  assign pop     = bp.if_valid && ras_ret;
  assign bp.pred_target = ras_ret ? ras[ptr - RW'(1)] : bp.pred_taken ? target[ri] : seq_pc;
  // ptr is the next free slot; a push when full wraps onto the oldest entry
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr   <= '0;
      depth <= '0;
    end else if (bp.ras_flush) begin
      ptr   <= '0;
      depth <= '0;
    end else if (push) begin
      ptr   <= ptr + RW'(1);
      depth <= depth == (RW+1)'(RAS_SIZE) ? depth : depth + (RW+1)'(1);
    end else if (pop) begin
      ptr   <= ptr - RW'(1);
      depth <= depth - (RW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push && !bp.ras_flush) ras[ptr] <= seq_pc;
`else
  logic [RW-1:0] unused_ras;
  assign unused_ras     = RW'(bp.if_valid ^ bp.ras_flush);
  assign bp.pred_target = bp.pred_taken ? target[ri] : seq_pc;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vectors for BTB training, aliasing, RAS and reset behaviour.
module tb_branch_predictor;
  localparam logic [1:0] BR = 2'b00, CALL = 2'b10, RET = 2'b11;
`ifdef BRANCH_PRED_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] exp_tgt;
  branch_predictor_if #(.XLEN(32)) bp ();
  branch_predictor #(.XLEN(32), .BTB_SIZE(64), .RAS_SIZE(8)) dut (.clk(clk), .rst(rst), .bp(bp));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic upd(input logic [31:0] pc, input logic [1:0] t, input logic tk, input logic [31:0] tgt);
    bp.upd_pc = pc; bp.upd_type = t; bp.upd_taken = tk; bp.upd_target = tgt; bp.upd_valid = 1'b1;
    tick();
    bp.upd_valid = 1'b0;
  endtask
  task automatic fetch(input string nm, input logic [31:0] pc, input logic fv, input logic ev,
                       input logic et, input logic [31:0] etgt, input logic [1:0] es);
    bp.if_pc = pc; bp.if_valid = fv;
    #1;
    chk({nm, ".valid"}, 32'(bp.pred_valid), 32'(ev));
    chk({nm, ".taken"}, 32'(bp.pred_taken), 32'(et));
    chk({nm, ".target"}, bp.pred_target, etgt);
    chk({nm, ".state"}, 32'(bp.pred_state), 32'(es));
    tick();
    bp.if_valid = 1'b0;
  endtask
  initial begin
    bp.if_valid = 0; bp.if_pc = 32'h100; bp.upd_valid = 0; bp.upd_pc = 0;
    bp.upd_type = BR; bp.upd_taken = 0; bp.upd_target = 0; bp.ras_flush = 0;
    repeat (2) tick();
    rst = 1'b0;
    fetch("reset", 32'h100, 0, 0, 0, 32'h104, 2'b00);
    upd(32'h100, BR, 1, 32'h80);
    fetch("train1", 32'h100, 0, 1, 1, 32'h80, 2'b10);
    upd(32'h100, BR, 0, 32'h80);
    upd(32'h100, BR, 0, 32'h80);
    fetch("train_nt", 32'h100, 0, 1, 0, 32'h104, 2'b00);
    repeat (3) upd(32'h100, BR, 1, 32'h80);
    fetch("train_t", 32'h100, 0, 1, 1, 32'h80, 2'b11);
    upd(32'h100, BR, 1, 32'h80);
    fetch("saturate", 32'h100, 0, 1, 1, 32'h80, 2'b11);
    bp.upd_pc = 32'h100; bp.upd_type = BR; bp.upd_taken = 0; bp.upd_target = 32'h80;
    bp.upd_valid = 1'b1; bp.if_pc = 32'h100;
    #1;
    chk("rbw.state", 32'(bp.pred_state), 32'h3);
    chk("rbw.target", bp.pred_target, 32'h80);
    tick();
    bp.upd_valid = 1'b0;
    fetch("after_rbw", 32'h100, 0, 1, 1, 32'h80, 2'b10);
    upd(32'h200, BR, 1, 32'h300);
    fetch("alias_old", 32'h100, 0, 0, 0, 32'h104, 2'b00);
    fetch("alias_new", 32'h200, 0, 1, 1, 32'h300, 2'b10);
    upd(32'h40, CALL, 1, 32'h400);
    upd(32'h41C, RET, 1, 32'h88);
    fetch("call", 32'h40, 1, 1, 1, 32'h400, 2'b11);
    fetch("ret", 32'h41C, 1, 1, 1, RAS ? 32'h44 : 32'h88, 2'b11);
    fetch("ret_empty", 32'h41C, 1, 1, 1, 32'h88, 2'b11);
    for (int k = 0; k < 9; k++) upd(32'h1000 + 32'(4 * k), CALL, 1, 32'h2000);
    for (int k = 0; k < 9; k++)
      fetch($sformatf("push%0d", k), 32'h1000 + 32'(4 * k), 1, 1, 1, 32'h2000, 2'b11);
    upd(32'h41C, RET, 1, 32'h88);
    for (int j = 0; j < 9; j++) begin
      exp_tgt = (RAS && j < 8) ? 32'h1004 + 32'(4 * (8 - j)) : 32'h88;
      fetch($sformatf("pop%0d", j), 32'h41C, 1, 1, 1, exp_tgt, 2'b11);
    end
    fetch("pre_flush", 32'h1004, 1, 1, 1, 32'h2000, 2'b11);
    bp.ras_flush = 1'b1;
    fetch("flush_push", 32'h1000, 1, 1, 1, 32'h2000, 2'b11);
    bp.ras_flush = 1'b0;
    fetch("post_flush", 32'h41C, 1, 1, 1, 32'h88, 2'b11);
    bp.upd_pc = 32'h300; bp.upd_type = BR; bp.upd_taken = 1; bp.upd_target = 32'h500;
    bp.upd_valid = 1'b1;
    #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bp.upd_valid = 1'b0;
    fetch("rst_a", 32'h1000, 0, 0, 0, 32'h1004, 2'b00);
    fetch("rst_b", 32'h41C, 0, 0, 0, 32'h420, 2'b00);
    fetch("rst_c", 32'h300, 0, 0, 0, 32'h304, 2'b00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
